vga_timing_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 sync generator.
- Produces HS/VS, data-enable, pixel coordinates, line/frame pulses, animate tick and a frame counter for any timing set.
- All outputs are registered.
- Sits between the pixel-strobe divider and the pixel/sprite renderer; one instance per display pipeline.

---
 rtl/vga_timing_gen.sv | 150 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/timing generator: HS/VS, data-enable, coordinates, line/frame/animate pulses.
// Optional colour-bar test pattern on o_tp_rgb when VGA_TIMING_TESTPAT_EN is defined.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int XW       = 10,
    parameter int YW       = 9,
    parameter int FCW      = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_pix_stb,
    output logic            o_hs,
    output logic            o_vs,
    output logic            o_de,
    output logic [XW-1:0]   o_x,
    output logic [YW-1:0]   o_y,
    output logic            o_line_start,
    output logic            o_frame_start,
    output logic            o_animate,
    output logic [FCW-1:0]  o_frame_cnt,
    output logic [11:0]     o_tp_rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);

    localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] H_ACT    = HCW'(H_ACTIVE);
    localparam logic [HCW-1:0] HS_START = HCW'(H_ACTIVE + H_FP);
    localparam logic [HCW-1:0] HS_END   = HCW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] V_ACT    = VCW'(V_ACTIVE);
    localparam logic [VCW-1:0] V_ANIM   = VCW'(V_ACTIVE - 1);
    localparam logic [VCW-1:0] VS_START = VCW'(V_ACTIVE + V_FP);
    localparam logic [VCW-1:0] VS_END   = VCW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HCW-1:0] h_cnt, h_nxt;
    logic [VCW-1:0] v_cnt, v_nxt;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        h_nxt = h_cnt + HCW'(1);
        v_nxt = v_cnt;
        if (h_cnt == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + VCW'(1);
        end
    end

    // Outputs are decoded from the next position so they line up with the counters.
    logic          hs_zone, vs_zone, de_nxt;
    logic          line_start_nxt, frame_start_nxt, animate_nxt;
    logic [XW-1:0] x_nxt;
    logic [YW-1:0] y_nxt;

    assign hs_zone         = (h_nxt >= HS_START) && (h_nxt < HS_END);
    assign vs_zone         = (v_nxt >= VS_START) && (v_nxt < VS_END);
    assign de_nxt          = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    assign x_nxt           = de_nxt ? XW'(h_nxt) : '0;
    assign y_nxt           = de_nxt ? YW'(v_nxt) : '0;
    assign line_start_nxt  = (h_nxt == '0);
    assign frame_start_nxt = (h_nxt == '0) && (v_nxt == '0);
    assign animate_nxt     = (h_nxt == H_ACT) && (v_nxt == V_ANIM);

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt         <= H_LAST;
            v_cnt         <= V_LAST;
            o_hs          <= ~HS_POL;
            o_vs          <= ~VS_POL;
            o_de          <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            o_animate     <= 1'b0;
            o_frame_cnt   <= '0;
        end else begin
            // Pulses last exactly one i_clk, independent of the strobe rate.
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            o_animate     <= 1'b0;
            if (i_pix_stb) begin
                h_cnt         <= h_nxt;
                v_cnt         <= v_nxt;
                o_hs          <= hs_zone ? HS_POL : ~HS_POL;
                o_vs          <= vs_zone ? VS_POL : ~VS_POL;
                o_de          <= de_nxt;
                o_x           <= x_nxt;
                o_y           <= y_nxt;
                o_line_start  <= line_start_nxt;
                o_frame_start <= frame_start_nxt;
                o_animate     <= animate_nxt;
                if (frame_start_nxt)
                    o_frame_cnt <= o_frame_cnt + FCW'(1);
            end
        end
    end

`ifdef VGA_TIMING_TESTPAT_EN
    // Eight equal bars; columns past 8*BAR_W fold into the last bar.
    localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

    logic [2:0]  bar_idx;
    logic [11:0] tp_nxt;

    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (int'(x_nxt) >= k * BAR_W)
                bar_idx = 3'(k);
        end
        tp_nxt = 12'h000;
        case (bar_idx)
            3'd0:    tp_nxt = 12'hFFF;
            3'd1:    tp_nxt = 12'hFF0;
            3'd2:    tp_nxt = 12'h0FF;
            3'd3:    tp_nxt = 12'h0F0;
            3'd4:    tp_nxt = 12'hF0F;
            3'd5:    tp_nxt = 12'hF00;
            3'd6:    tp_nxt = 12'h00F;
            default: tp_nxt = 12'h000;
        endcase
        if (!de_nxt)
            tp_nxt = 12'h000;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_tp_rgb <= '0;
        else if (i_pix_stb)
            o_tp_rgb <= tp_nxt;
    end
`else
    assign o_tp_rgb = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480, reduced with 3-clock strobe and FCW=2,
// reduced with positive polarity and strobe tied high) checked every cycle against a position model.
module tb_vga_timing_gen;

    logic clk, rst_n;
    logic stb_a, stb_b, stb_c;
    int   b_ph;

    logic        hs_a, vs_a, de_a, ls_a, fs_a, an_a;
    logic [9:0]  x_a;
    logic [8:0]  y_a;
    logic [7:0]  fc_a;
    logic [11:0] rgb_a;

    logic        hs_b, vs_b, de_b, ls_b, fs_b, an_b;
    logic [2:0]  x_b;
    logic [1:0]  y_b;
    logic [1:0]  fc_b;
    logic [11:0] rgb_b;

    logic        hs_c, vs_c, de_c, ls_c, fs_c, an_c;
    logic [2:0]  x_c;
    logic [1:0]  y_c;
    logic [7:0]  fc_c;
    logic [11:0] rgb_c;

    vga_timing_gen u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(stb_a),
        .o_hs(hs_a), .o_vs(vs_a), .o_de(de_a), .o_x(x_a), .o_y(y_a),
        .o_line_start(ls_a), .o_frame_start(fs_a), .o_animate(an_a),
        .o_frame_cnt(fc_a), .o_tp_rgb(rgb_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .XW(3), .YW(2), .FCW(2)
    ) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(stb_b),
        .o_hs(hs_b), .o_vs(vs_b), .o_de(de_b), .o_x(x_b), .o_y(y_b),
        .o_line_start(ls_b), .o_frame_start(fs_b), .o_animate(an_b),
        .o_frame_cnt(fc_b), .o_tp_rgb(rgb_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1),
        .XW(3), .YW(2), .FCW(8)
    ) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(stb_c),
        .o_hs(hs_c), .o_vs(vs_c), .o_de(de_c), .o_x(x_c), .o_y(y_c),
        .o_line_start(ls_c), .o_frame_start(fs_c), .o_animate(an_c),
        .o_frame_cnt(fc_c), .o_tp_rgb(rgb_c)
    );

`ifdef VGA_TIMING_TESTPAT_EN
    localparam int TP_X0  = 12'hFFF;
    localparam int TP_X80 = 12'hFF0;
`else
    localparam int TP_X0  = 0;
    localparam int TP_X80 = 0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit hs, vs, de, ls, fs, an;
        int x, y, fc, rgb;
    } exp_t;

    function automatic int frame_len(input int k);
        return (k == 0) ? 800 * 525 : 14 * 7;
    endfunction

    // Expected outputs for instance k sitting at linear position pos (0 = first active pixel).
    function automatic exp_t model(input int k, input int pos, input bit stepped, input int frames);
        int ha, hf, hsw, hb, va, vf, vsw, fcw, ht, h, v, bar;
        bit hp, vp;
        int pal[8];
        exp_t e;
        if (k == 0) begin
            ha = 640; hf = 16; hsw = 96; hb = 48; va = 480; vf = 10; vsw = 2;
            fcw = 8; hp = 1'b0; vp = 1'b0;
        end else begin
            ha = 8; hf = 2; hsw = 3; hb = 1; va = 4; vf = 1; vsw = 1;
            fcw = (k == 1) ? 2 : 8; hp = (k == 2); vp = (k == 2);
        end
        ht = ha + hf + hsw + hb;
        h  = pos % ht;
        v  = pos / ht;
        e.de  = (h < ha) && (v < va);
        e.x   = e.de ? h : 0;
        e.y   = e.de ? v : 0;
        e.hs  = (h >= ha + hf && h < ha + hf + hsw) ? hp : !hp;
        e.vs  = (v >= va + vf && v < va + vf + vsw) ? vp : !vp;
        e.ls  = stepped && (h == 0);
        e.fs  = stepped && (pos == 0);
        e.an  = stepped && (h == ha) && (v == va - 1);
        e.fc  = frames % (1 << fcw);
        e.rgb = 0;
`ifdef VGA_TIMING_TESTPAT_EN
        pal = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        if (e.de) begin
            bar = e.x / (ha / 8);
            if (bar > 7) bar = 7;
            e.rgb = pal[bar];
        end
`else
        pal = '{0, 0, 0, 0, 0, 0, 0, 0};
        bar = 0;
        e.rgb = pal[bar];
`endif
        return e;
    endfunction

    int pos_m[3];
    int frm_m[3];
    bit stp_m[3];

    always @(posedge clk or negedge rst_n) begin
        bit sv[3];
        sv = '{stb_a, stb_b, stb_c};
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                pos_m[k] = frame_len(k) - 1;
                frm_m[k] = 0;
                stp_m[k] = 1'b0;
            end else begin
                stp_m[k] = sv[k];
                if (sv[k]) begin
                    pos_m[k] = (pos_m[k] + 1) % frame_len(k);
                    if (pos_m[k] == 0) frm_m[k]++;
                end
            end
        end
    end

    task automatic cmp(input int k, input logic hs, input logic vs, input logic de,
                       input logic [31:0] x, input logic [31:0] y, input logic ls,
                       input logic fs, input logic an, input logic [31:0] fc,
                       input logic [31:0] rgb);
        exp_t e;
        e = model(k, pos_m[k], stp_m[k], frm_m[k]);
        check($sformatf("dut%0d hs", k), 32'(hs), 32'(e.hs));
        check($sformatf("dut%0d vs", k), 32'(vs), 32'(e.vs));
        check($sformatf("dut%0d de", k), 32'(de), 32'(e.de));
        check($sformatf("dut%0d x", k), x, e.x);
        check($sformatf("dut%0d y", k), y, e.y);
        check($sformatf("dut%0d line_start", k), 32'(ls), 32'(e.ls));
        check($sformatf("dut%0d frame_start", k), 32'(fs), 32'(e.fs));
        check($sformatf("dut%0d animate", k), 32'(an), 32'(e.an));
        check($sformatf("dut%0d frame_cnt", k), fc, e.fc);
        check($sformatf("dut%0d tp_rgb", k), rgb, e.rgb);
    endtask

    // Single compare process, mid-low-phase of the clock.
    always @(negedge clk) begin
        cmp(0, hs_a, vs_a, de_a, 32'(x_a), 32'(y_a), ls_a, fs_a, an_a, 32'(fc_a), 32'(rgb_a));
        cmp(1, hs_b, vs_b, de_b, 32'(x_b), 32'(y_b), ls_b, fs_b, an_b, 32'(fc_b), 32'(rgb_b));
        cmp(2, hs_c, vs_c, de_c, 32'(x_c), 32'(y_c), ls_c, fs_c, an_c, 32'(fc_c), 32'(rgb_c));
    end

    // ---------------- clock, strobe, monitors ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // B strobe: one clock in three.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            stb_b = (b_ph == 0);
            b_ph  = (b_ph + 1) % 3;
        end
    end

    int fcq[$];
    always @(negedge clk) begin
        if (rst_n && fs_b && fcq.size() < 5) fcq.push_back(int'(fc_b));
    end

    // ---------------- directed sequence ----------------
    initial begin
        int hs_low, hs_first, ls_cnt, per, an_cnt, de_cnt, max_x, max_y, guard;
        int fexp[5];
        fexp = '{1, 2, 3, 0, 1};
        rst_n = 1'b0;
        stb_a = 1'b0; stb_b = 1'b0; stb_c = 1'b0; b_ph = 0;

        repeat (3) @(negedge clk);
        check("A reset hs", 32'(hs_a), 1);
        check("A reset vs", 32'(vs_a), 1);
        check("A reset de", 32'(de_a), 0);
        check("A reset frame_cnt", 32'(fc_a), 0);
        check("C reset hs", 32'(hs_c), 0);
        check("C reset vs", 32'(vs_c), 0);

        rst_n = 1'b1;
        stb_a = 1'b1; stb_c = 1'b1; stb_b = 1'b1; b_ph = 1;
        @(negedge clk);
        check("A first frame_start", 32'(fs_a), 1);
        check("A first line_start", 32'(ls_a), 1);
        check("A first de", 32'(de_a), 1);
        check("A first frame_cnt", 32'(fc_a), 1);
        check("A first x", 32'(x_a), 0);
        check("A first tp_rgb", 32'(rgb_a), TP_X0);
        check("B first frame_start", 32'(fs_b), 1);
        check("B first frame_cnt", 32'(fc_b), 1);

        // One full default line starting at h=0.
        hs_low = 0; hs_first = -1; ls_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            if (ls_a) ls_cnt++;
            if (!hs_a) begin
                hs_low++;
                if (hs_first < 0) hs_first = i;
            end
            if (i == 80)  check("A tp_rgb x80", 32'(rgb_a), TP_X80);
            if (i == 639) check("A tp_rgb x639", 32'(rgb_a), 0);
            if (i == 700) check("A tp_rgb blank", 32'(rgb_a), 0);
            @(negedge clk);
        end
        check("A line_start per line", ls_cnt, 1);
        check("A line period 800", 32'(ls_a), 1);
        check("A hs low clocks", hs_low, 96);
        check("A hs first low h", hs_first, 656);

        // B frame counter wrap over 5 frames.
        guard = 0;
        while (fcq.size() < 5 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("B five frames seen", fcq.size(), 5);
        for (int i = 0; i < 5 && i < fcq.size(); i++)
            check($sformatf("B frame_cnt seq %0d", i), fcq[i], fexp[i]);

        // B one complete frame with the 3-clock strobe.
        guard = 0;
        while (!fs_b && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("B frame_start seen", 32'(fs_b), 1);
        per = 0; an_cnt = 0; ls_cnt = 0; de_cnt = 0; max_x = 0; max_y = 0;
        do begin
            if (an_b) an_cnt++;
            if (ls_b) ls_cnt++;
            if (de_b) de_cnt++;
            if (int'(x_b) > max_x) max_x = int'(x_b);
            if (int'(y_b) > max_y) max_y = int'(y_b);
            per++;
            @(negedge clk);
        end while (!fs_b && per < 400);
        check("B frame period", per, 294);
        check("B animate clocks", an_cnt, 1);
        check("B line_start clocks", ls_cnt, 7);
        check("B de clocks", de_cnt, 96);
        check("B max x", max_x, 7);
        check("B max y", max_y, 3);

        // C one frame with strobe tied high.
        guard = 0;
        while (!fs_c && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("C frame_start seen", 32'(fs_c), 1);
        per = 0; an_cnt = 0;
        do begin
            if (an_c) an_cnt++;
            per++;
            @(negedge clk);
        end while (!fs_c && per < 300);
        check("C frame period", per, 98);
        check("C animate clocks", an_cnt, 1);

        // Asynchronous reset mid-line at B (v=2, h=5).
        guard = 0;
        while (pos_m[1] != 2 * 14 + 5 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("B reached v2 h5", pos_m[1], 33);
        check("B x before reset", 32'(x_b), 5);
        #2 rst_n = 1'b0;
        #1;
        check("B async reset de", 32'(de_b), 0);
        check("B async reset x", 32'(x_b), 0);
        check("B async reset y", 32'(y_b), 0);
        check("B async reset frame_cnt", 32'(fc_b), 0);
        check("B async reset hs", 32'(hs_b), 1);
        check("B async reset vs", 32'(vs_b), 1);
        check("C async reset hs", 32'(hs_c), 0);
        @(negedge clk);
        rst_n = 1'b1;
        stb_b = 1'b1; b_ph = 1;
        @(negedge clk);
        check("B post-reset frame_start", 32'(fs_b), 1);
        check("B post-reset frame_cnt", 32'(fc_b), 1);
        check("B post-reset de", 32'(de_b), 1);
        check("B post-reset x", 32'(x_b), 0);
        check("B post-reset y", 32'(y_b), 0);

        repeat (60) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
